// File: rtl/fetch_pc_unit.sv
// Purpose: architectural PC register and instruction-fetch sequencer. It handles redirects, stalls, squashes and halt.
// Latency: all outputs are registered. Zero-wait memory gives one fetch per cycle. fetch_valid rises on the edge after imem_ack.
// Backpressure: a stall seen on an ack parks the fetched instruction in HOLD with no new request; the build option PC_ALIGN_CHECK_EN enables the misaligned-target halt.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seq_pc,
  output logic [31:0] instr_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] fpc_nxt;
  logic        fv_nxt;
  logic        req_nxt;
  logic        pend_vld, pend_vld_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic [31:0] redir_tgt;
  logic        redir_bad;
`ifdef PC_ALIGN_CHECK_EN
  logic        err_q, err_nxt;
`endif

  // Redirect target: a branch arriving this cycle beats an older pending one.
  always_comb begin
    redir_tgt = branch_valid ? branch_target : pend_tgt;
`ifdef PC_ALIGN_CHECK_EN
    redir_bad = (redir_tgt[1:0] != 2'b00);
`else
    redir_tgt[1:0] = 2'b00;
    redir_bad = 1'b0;
`endif
  end

  // Next-state and next-register values; halt overrides everything else.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = instr_addr;
    fpc_nxt      = fetch_pc;
    fv_nxt       = fetch_valid;
    pend_vld_nxt = pend_vld;
    pend_tgt_nxt = pend_tgt;
`ifdef PC_ALIGN_CHECK_EN
    err_nxt      = err_q;
`endif
    if (halt) begin
      state_nxt = HALTED;
      fv_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: state_nxt = FETCH;
        FETCH: begin
          if (imem_ack) begin
            if (branch_valid || pend_vld) begin
              // The returned instruction is on the wrong path, so it is squashed.
              pend_vld_nxt = 1'b0;
              fv_nxt       = 1'b0;
              if (redir_bad) begin
`ifdef PC_ALIGN_CHECK_EN
                err_nxt = 1'b1;
`endif
                state_nxt = HALTED;
              end else begin
                addr_nxt = redir_tgt;
              end
            end else begin
              fpc_nxt  = instr_addr;
              addr_nxt = seq_pc;
              fv_nxt   = 1'b1;
              if (stall) state_nxt = HOLD;
            end
          end else begin
            // The in-flight request stays up, and a redirect waits for its ack.
            fv_nxt = 1'b0;
            if (branch_valid) begin
              pend_vld_nxt = 1'b1;
              pend_tgt_nxt = branch_target;
            end
          end
        end
        HOLD: begin
          if (branch_valid) begin
            fv_nxt = 1'b0;
            if (redir_bad) begin
`ifdef PC_ALIGN_CHECK_EN
              err_nxt = 1'b1;
`endif
              state_nxt = HALTED;
            end else begin
              addr_nxt  = redir_tgt;
              state_nxt = FETCH;
            end
          end else if (!stall) begin
            fv_nxt    = 1'b0;
            state_nxt = FETCH;
          end
        end
        HALTED: state_nxt = HALTED;
        default: state_nxt = IDLE;
      endcase
    end
    req_nxt = (state_nxt == FETCH);
  end

  // State register plus registered outputs; reset is asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      instr_addr  <= RESET_PC;
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
      imem_req    <= 1'b0;
      pend_vld    <= 1'b0;
      pend_tgt    <= 32'h0;
    end else begin
      state       <= state_nxt;
      instr_addr  <= addr_nxt;
      fetch_pc    <= fpc_nxt;
      fetch_valid <= fv_nxt;
      imem_req    <= req_nxt;
      pend_vld    <= pend_vld_nxt;
      pend_tgt    <= pend_tgt_nxt;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky misaligned-redirect flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_nxt;
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Purpose: self-checking bench for fetch_pc_unit. It uses directed test-plan scenarios and then random traffic.
// Latency: inputs change on the falling edge, and outputs are compared on the next falling edge.
// Backpressure: stall, ack delays, redirects and halt are all randomised against a flag-based reference model.
module tb_fetch_pc_unit;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seq_pc;
  logic [31:0] instr_addr;
  logic        imem_req;
  logic        imem_ack;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        halt;
  logic        misalign_err;

  always #5 clk = ~clk;

  // The PC incrementer that sits outside the unit.
  assign seq_pc = instr_addr + 32'd4;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .seq_pc(seq_pc), .instr_addr(instr_addr),
    .imem_req(imem_req), .imem_ack(imem_ack), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .halt(halt), .misalign_err(misalign_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model state, described as plain flags rather than as a state machine.
  logic [31:0] m_pc, m_fpc;
  logic        m_fv, m_req, m_err;
  logic        m_started, m_hold, m_halted;
  logic [31:0] m_pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, obs, want);
  endtask

  task automatic check_all();
    chk("instr_addr", instr_addr, m_pc);
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_fpc = RST_PC; m_fv = 0; m_req = 0; m_err = 0;
    m_started = 0; m_hold = 0; m_halted = 0;
    m_pend.delete();
  endtask

  task automatic model_redirect(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    if (t[1:0] != 2'b00) begin
      m_err = 1; m_halted = 1; m_req = 0;
    end else begin
      m_pc = t; m_req = 1;
    end
`else
    m_pc = t & 32'hFFFF_FFFC;
    m_req = 1;
`endif
    m_fv = 0;
    m_hold = 0;
  endtask

  task automatic model_step(input logic a, input logic s, input logic bv,
                            input logic [31:0] bt, input logic h);
    logic [31:0] t;
    if (m_halted) return;
    if (h) begin
      m_halted = 1; m_req = 0; m_fv = 0;
      return;
    end
    if (!m_started) begin
      m_started = 1; m_req = 1;
      return;
    end
    if (m_hold) begin
      if (bv) model_redirect(bt);
      else if (!s) begin m_hold = 0; m_fv = 0; m_req = 1; end
      return;
    end
    if (a) begin
      if (bv) begin
        m_pend.delete();
        model_redirect(bt);
      end else if (m_pend.size() > 0) begin
        t = m_pend.pop_front();
        model_redirect(t);
      end else begin
        m_fpc = m_pc;
        m_pc  = m_pc + 32'd4;
        m_fv  = 1;
        if (s) begin m_hold = 1; m_req = 0; end
      end
    end else begin
      m_fv = 0;
      if (bv) begin
        m_pend.delete();
        m_pend.push_back(bt);
      end
    end
  endtask

  // Each call starts at a falling edge, drives inputs for one cycle, then checks.
  task automatic step(input logic a, input logic s, input logic bv,
                      input logic [31:0] bt, input logic h);
    imem_ack = a; stall = s; branch_valid = bv; branch_target = bt; halt = h;
    model_step(a, s, bv, bt, h);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 0; stall = 0; branch_valid = 0; branch_target = 0; halt = 0;
  endtask

  initial begin
    logic a, s, bv, h;
    logic [31:0] bt;
    rst = 1'b1; imem_ack = 0; stall = 0; branch_valid = 0; branch_target = 0; halt = 0;
    @(negedge clk);
    do_reset();
    chk("rst_addr", instr_addr, 32'h100);
    chk("rst_req", {31'b0, imem_req}, 32'h0);

    // Zero-wait memory: one bubble, then fetches at 0x100, 0x104 and 0x108.
    step(1, 0, 0, 0, 0);
    chk("req_after_release", {31'b0, imem_req}, 32'h1);
    chk("no_valid_yet", {31'b0, fetch_valid}, 32'h0);
    step(1, 0, 0, 0, 0); chk("zw_pc0", fetch_pc, 32'h100);
    step(1, 0, 0, 0, 0); chk("zw_pc1", fetch_pc, 32'h104);
    step(1, 0, 0, 0, 0); chk("zw_pc2", fetch_pc, 32'h108);
    chk("zw_valid", {31'b0, fetch_valid}, 32'h1);

    // Ack delayed by three cycles.
    do_reset();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk("wait_addr", instr_addr, 32'h100);
    chk("wait_valid", {31'b0, fetch_valid}, 32'h0);
    step(1, 0, 0, 0, 0);
    chk("wait_done_pc", fetch_pc, 32'h100);

    // A stall arriving with the ack at 0x104 parks the fetch in HOLD.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("hold_pc", fetch_pc, 32'h104);
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("after_hold_pc", fetch_pc, 32'h108);

    // A branch that arrives while waiting squashes the returning fetch.
    step(0, 0, 1, 32'h400, 0);
    step(1, 0, 0, 0, 0);
    chk("br_addr", instr_addr, 32'h400);
    chk("br_squash", {31'b0, fetch_valid}, 32'h0);
    step(1, 0, 0, 0, 0);
    chk("br_target_pc", fetch_pc, 32'h400);

    // A halt together with an ack is terminal until reset.
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h800, 0);
    chk("halt_addr", instr_addr, 32'h404);
    chk("halt_req", {31'b0, imem_req}, 32'h0);
    do_reset();
    chk("halt_rst_addr", instr_addr, 32'h100);

    // Misaligned redirect.
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h402, 0);
    step(1, 0, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_err", {31'b0, misalign_err}, 32'h1);
    chk("mis_req", {31'b0, imem_req}, 32'h0);
`else
    chk("mis_addr", instr_addr, 32'h400);
    chk("mis_err", {31'b0, misalign_err}, 32'h0);
`endif

    // Random traffic, including wrap near the top of the address space and random resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 249) == 0) begin
        do_reset();
      end
      a  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 3) == 0);
      bv = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 149) == 0);
      case ($urandom_range(0, 7))
        0:       bt = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
        1:       bt = $urandom;
        default: bt = $urandom & 32'h0000_FFFC;
      endcase
      step(a, s, bv, bt, h);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
